rr_arb_mux: RTL and testbench

- Parametrised successor to the team's 4:1 combinational mux.
- N-input, DATA_W-wide selector with a valid/ready handshake on every input and on the output.
- Two selection modes: fixed (external select) and round-robin arbitration.
- Result is registered, one cycle of latency. Used wherever several producers share one downstream consumer.

---
 rtl/rr_arb_mux_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/rr_arb_mux.sv | 86 ++++++++
 tb/tb_rr_arb_mux.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the rr_arb_mux selector family.
// Mode encoding and select-width derivation live here so every user agrees on them.
package rr_arb_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of an index field for n channels; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr,
// wrapping past the last channel. en low suppresses every grant.
module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  logic found;
  int   idx;

  // Walk the channels in priority order starting at ptr; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (int'(ptr) + k) % NUM_IN;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input valid/ready selector with fixed or round-robin channel choice and a
// single registered output stage that sustains one transfer per cycle.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_src,
  input  logic                     out_ready
);

  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  rr_idx;
  logic [SEL_W-1:0]  grant_idx;
  logic [SEL_W-1:0]  rr_next;
  logic [NUM_IN-1:0] rr_grant;
  logic [NUM_IN-1:0] fixed_grant;
  logic [NUM_IN-1:0] grant;
  logic [DATA_W-1:0] pick_data;
  logic              load_en;
  logic              xfer;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_arbiter (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .en        (mode == MODE_RR),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // Loop compare keeps an out-of-range sel from indexing past in_valid.
  always_comb begin
    fixed_grant = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(sel) == i) fixed_grant[i] = in_valid[i];
    end
  end

  always_comb begin
    grant     = (mode == MODE_RR) ? rr_grant : fixed_grant;
    grant_idx = (mode == MODE_RR) ? rr_idx   : sel;
    load_en   = !out_valid || out_ready;
    in_ready  = (rst_n && load_en) ? grant : '0;
    xfer      = |in_ready;
    rr_next   = (int'(grant_idx) == NUM_IN - 1) ? '0 : grant_idx + 1'b1;
  end

  // AND-OR mux driven by the one-hot grant so unselected lanes never reach out_data.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) pick_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= pick_data;
        out_src  <= grant_idx;
        if (mode == MODE_RR) rr_ptr <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Randomised scoreboard bench for rr_arb_mux with a queue-based reference model.
// Directed phases cover reset, fixed select, fairness, backpressure, wrap and async reset.
module tb_rr_arb_mux;

  localparam int NUM_IN = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_src;
  logic                     out_ready;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  src;
  } item_t;

  item_t sb[$];
  int    model_ptr = 0;
  int    checks = 0;
  int    errors = 0;

  rr_arb_mux #(
    .NUM_IN (NUM_IN),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle at the falling edge, then predict what the next rising edge accepts.
  task automatic applyStimulus(input logic m, input logic [SEL_W-1:0] s, input logic [NUM_IN-1:0] v,
                               input logic [NUM_IN*DATA_W-1:0] d, input logic r);
    int                winner;
    int                ch;
    logic              load;
    logic [NUM_IN-1:0] exp_ready;
    item_t             it;
    @(negedge clk);
    mode = m; sel = s; in_valid = v; in_data = d; out_ready = r;
    #2;
    load   = (sb.size() == 0);
    winner = -1;
    if (m == 1'b0) begin
      if (int'(s) < NUM_IN && v[s]) winner = int'(s);
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        ch = (model_ptr + k) % NUM_IN;
        if (winner < 0 && v[ch]) winner = ch;
      end
    end
    exp_ready = (load && winner >= 0) ? NUM_IN'(1 << winner) : '0;
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    if (load && winner >= 0) begin
      it.data = d[winner*DATA_W +: DATA_W];
      it.src  = SEL_W'(winner);
      sb.push_back(it);
      if (m) model_ptr = (winner + 1) % NUM_IN;
    end
  endtask

  // Monitor: runs just before the driver each cycle and retires accepted items.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        checkOutput("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (out_valid && sb.size() != 0) begin
          checkOutput("out_data", 32'(out_data), 32'(sb[0].data));
          checkOutput("out_src", 32'(out_src), 32'(sb[0].src));
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  localparam logic [31:0] SEQ_DATA = 32'h13121110;

  initial begin
    rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = '1; in_data = SEQ_DATA; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_out_src", 32'(out_src), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b1;

    // Fixed select, then a sel change.
    repeat (4) applyStimulus(1'b0, 2'd2, 4'b1111, SEQ_DATA, 1'b1);
    repeat (2) applyStimulus(1'b0, 2'd1, 4'b1111, SEQ_DATA, 1'b1);

    // Round-robin fairness, then with channel 1 idle.
    repeat (8) applyStimulus(1'b1, 2'd0, 4'b1111, SEQ_DATA, 1'b1);
    repeat (4) applyStimulus(1'b1, 2'd0, 4'b1101, SEQ_DATA, 1'b1);

    // Backpressure for three cycles after a transfer.
    applyStimulus(1'b1, 2'd0, 4'b1111, SEQ_DATA, 1'b1);
    repeat (3) applyStimulus(1'b1, 2'd0, 4'b1111, SEQ_DATA, 1'b0);
    repeat (4) applyStimulus(1'b1, 2'd0, 4'b1111, SEQ_DATA, 1'b1);

    // Sparse requests with pointer wrap, then idle.
    applyStimulus(1'b1, 2'd0, 4'b1000, 32'hA3A2A1A0, 1'b1);
    applyStimulus(1'b1, 2'd0, 4'b0001, 32'hB3B2B1B0, 1'b1);
    applyStimulus(1'b1, 2'd0, 4'b0011, 32'hC3C2C1C0, 1'b1);
    repeat (3) applyStimulus(1'b1, 2'd0, 4'b0000, SEQ_DATA, 1'b1);

    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, 3)),
                    NUM_IN'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
    end

    // Async reset between edges while the output is occupied.
    repeat (2) applyStimulus(1'b1, 2'd0, 4'b1111, SEQ_DATA, 1'b1);
    @(posedge clk);
    #2;
    checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
    sb.delete();
    model_ptr = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(1'b1, 2'd0, 4'b0110, 32'hD3D2D1D0, 1'b1);
    repeat (4) applyStimulus(1'b1, 2'd0, 4'b1111, SEQ_DATA, 1'b1);

    repeat (3) applyStimulus(1'b1, 2'd0, 4'b0000, SEQ_DATA, 1'b1);
    @(negedge clk);
    #3;
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
